rr_prio_arbiter: RTL

- Parametrised, registered successor to the 8-bit combinational priority encoder.
- Accepts N request lines and picks one winner, either by fixed priority (highest index wins) or by rotating round-robin priority.
- Presents the winner as index plus one-hot over a valid/ready handshake, and holds it stable until a consumer accepts it.
- Sits between request sources (DMA channels, interrupt lines) and a shared resource controller.

---
 rtl/rr_prio_arbiter_if.sv | 25 ++
 rtl/rr_prio_arbiter.sv | 106 ++++++++++
 2 files changed

// File: rtl/rr_prio_arbiter_if.sv
// Grant handshake bundle between request sources, the arbiter and the consumer.
// The arbiter takes the slave modport; the request/consumer side takes master.
interface rr_prio_arbiter_if #(
    parameter int N = 8
) ();
    localparam int W = $clog2(N);

    logic         mode;
    logic [N-1:0] req;
    logic         gnt_ready;
    logic         gnt_valid;
    logic [W-1:0] gnt_idx;
    logic [N-1:0] gnt_onehot;
    logic         busy;

    modport slave (
        input  mode, req, gnt_ready,
        output gnt_valid, gnt_idx, gnt_onehot, busy
    );

    modport master (
        output mode, req, gnt_ready,
        input  gnt_valid, gnt_idx, gnt_onehot, busy
    );
endinterface

// File: rtl/rr_prio_arbiter.sv
// Registered N-way arbiter, fixed or rotating priority, with a grant held
// stable over a valid/ready handshake until the consumer accepts it.
module rr_prio_arbiter #(
    parameter  int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic                clk,
    input  logic                rst_n,
    rr_prio_arbiter_if.slave    arb
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t       state_q, state_d;
    logic [W-1:0] ptr_q, ptr_d;
    logic [W-1:0] idx_q, idx_d;
    logic [N-1:0] onehot_q, onehot_d;

    logic [W-1:0] ptr_after;
    logic [W-1:0] arb_ptr;
    logic [W-1:0] win_idx;
    logic         handshake;

    // Pointer that the accepted grant leaves behind: one below it, wrapping to N-1.
    assign ptr_after = (idx_q == '0) ? W'(N - 1) : idx_q - W'(1);
    assign handshake = (state_q == GRANT) && arb.gnt_ready;

    // Back-to-back arbitration must already see the post-handshake pointer.
    always_comb begin
        arb_ptr = (state_q == GRANT) ? ptr_after : ptr_q;
        if (!arb.mode) begin
            arb_ptr = W'(N - 1);
        end
    end

    // Walk from lowest to highest priority so the last hit is the winner.
    always_comb begin
        int base;
        int pos;
        win_idx = '0;
        base    = int'(arb_ptr);
        for (int i = N - 1; i >= 0; i--) begin
            pos = (base >= i) ? base - i : base + N - i;
            if (arb.req[W'(pos)]) begin
                win_idx = W'(pos);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        idx_d    = idx_q;
        onehot_d = onehot_q;
        case (state_q)
            IDLE: begin
                if (|arb.req) begin
                    state_d           = GRANT;
                    idx_d             = win_idx;
                    onehot_d          = '0;
                    onehot_d[win_idx] = 1'b1;
                end
            end
            GRANT: begin
                if (handshake) begin
                    ptr_d = ptr_after;
                    if (|arb.req) begin
                        idx_d             = win_idx;
                        onehot_d          = '0;
                        onehot_d[win_idx] = 1'b1;
                    end else begin
                        state_d  = IDLE;
                        onehot_d = '0;
                    end
                end
            end
            default: begin
                state_d  = IDLE;
                onehot_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ptr_q    <= W'(N - 1);
            idx_q    <= '0;
            onehot_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            idx_q    <= idx_d;
            onehot_q <= onehot_d;
        end
    end

    assign arb.gnt_valid  = (state_q == GRANT);
    assign arb.busy       = (state_q == GRANT);
    assign arb.gnt_idx    = idx_q;
    assign arb.gnt_onehot = onehot_q;

endmodule
